// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, active-low
// gfedcba segment patterns, and the game-state code that means "playing".
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] GAME_PLAYING = 4'd0;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-low seven-segment pattern (gfedcba), purely combinational.
// Non-decimal nibbles light nothing.
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Periodic double-dabble conversion of the current/high score onto six HEX digits.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV = 500000,
    parameter int SCORE_W     = 18,
    parameter int DIGITS      = 6
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         game_state,
    input  logic [SCORE_W-1:0] currentScore,
    input  logic [SCORE_W-1:0] highScore,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5,
    output logic               disp_valid
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ITER_W = $clog2(SCORE_W + 1);
    localparam int BCD_W  = 4 * DIGITS;

    if (REFRESH_DIV <= SCORE_W + 3) begin : g_bad_div
        $error("score_display: REFRESH_DIV must exceed SCORE_W + 3");
    end
    if (DIGITS > 6 || (64'd10 ** DIGITS) < (64'd1 << SCORE_W)) begin : g_bad_digits
        $error("score_display: DIGITS must cover the score range and not exceed 6");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   refresh_cnt;
    logic               tick;
    logic [SCORE_W-1:0] bin_q, bin_shift;
    logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_shift;
    logic [ITER_W-1:0]  iter_q;
    logic [DIGITS-1:0]  blank;
    logic [6:0]         seg_dec [DIGITS];
    logic [6:0]         hex_q   [DIGITS];

    assign tick = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)    refresh_cnt <= '0;
        else if (tick) refresh_cnt <= '0;
        else           refresh_cnt <= refresh_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (iter_q == ITER_W'(SCORE_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction precedes the shift so every nibble stays decimal after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_shift = {bin_q[SCORE_W-2:0], 1'b0};
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dec
        seg7_decoder u_dec (.bcd(bcd_q[4*d +: 4]), .seg(seg_dec[d]));
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nonzero;
    always_comb begin
        blank        = '0;
        seen_nonzero = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (bcd_q[4*d +: 4] != 4'd0) seen_nonzero = 1'b1;
            blank[d] = !seen_nonzero;
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_valid <= 1'b0;
            for (int d = 0; d < DIGITS; d++) hex_q[d] <= SEG_0;
        end else begin
            case (state_q)
                LOAD: begin
                    bin_q  <= (game_state == GAME_PLAYING) ? currentScore : highScore;
                    bcd_q  <= '0;
                    iter_q <= '0;
                end
                SHIFT: begin
                    bin_q  <= bin_shift;
                    bcd_q  <= bcd_shift;
                    iter_q <= iter_q + ITER_W'(1);
                end
                DONE: begin
                    for (int d = 0; d < DIGITS; d++)
                        hex_q[d] <= blank[d] ? SEG_BLANK : seg_dec[d];
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Positions beyond DIGITS (when built narrower) stay dark.
    logic [6:0] hex_pad [6];
    for (genvar k = 0; k < 6; k++) begin : g_pad
        if (k < DIGITS) begin : g_used
            assign hex_pad[k] = hex_q[k];
        end else begin : g_unused
            assign hex_pad[k] = SEG_BLANK;
        end
    end

    assign HEX0 = hex_pad[0];
    assign HEX1 = hex_pad[1];
    assign HEX2 = hex_pad[2];
    assign HEX3 = hex_pad[3];
    assign HEX4 = hex_pad[4];
    assign HEX5 = hex_pad[5];

endmodule
